// File: rtl/irq_pend4.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pend4
//  Purpose  : Four-line edge-triggered interrupt pending register with a
//             masked, fixed-priority presenter. Bit 3 has the highest
//             priority. Events lost on lines that are already pending are
//             counted in a saturating overflow counter.
//  Ports    :
//    clk        in   1  clock, rising edge
//    rst        in   1  synchronous active-high reset
//    req        in   4  level request lines; a 0->1 transition posts an event
//    mask       in   4  per-line enable for presentation
//    irq_ack    in   1  consumer accepts the presented index
//    irq_valid  out  1  an index is being presented (registered)
//    irq_id     out  2  presented index (registered)
//    pend       out  4  pending-event vector (registered)
//    ovf_cnt    out  4  saturating count of lost events (registered)
//  Revision : 1.0  initial release
// ============================================================================
module irq_pend4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  output logic [3:0] pend,
  output logic [3:0] ovf_cnt
);

  // --------------------------------------------------------------------------
  // Presenter states
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  localparam logic [3:0] C_OVF_MAX  = 4'hF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0] req_q;      // previous-cycle copy of req for edge detection
  logic [3:0] pend_q,  pend_d;
  logic [3:0] ovf_q,   ovf_d;
  logic [1:0] state_q, state_d;
  logic [1:0] id_q,    id_d;
  logic       valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [3:0] w_edge;
  logic [3:0] w_clear;
  logic [3:0] w_elig;
  logic [3:0] w_lost;
  logic       w_accept;
  logic       w_win_any;
  logic [1:0] w_win_id;

  assign w_edge   = req & ~req_q;

  // An ack only counts while something is actually presented; a stray ack
  // in IDLE or GAP has no effect on anything.
  assign w_accept = (state_q == ST_PRESENT) & irq_ack;

  always_comb begin
    w_clear = 4'b0000;
    if (w_accept) begin
      w_clear[id_q] = 1'b1;
    end
  end

  // An edge on a bit that stays pending (not cleared this cycle) is lost.
  // An edge coinciding with the ack of the same line re-arms the bit instead.
  assign w_lost = w_edge & pend_q & ~w_clear;

  assign w_elig = pend_q & mask;

  // Fixed-priority encoder, bit 3 wins.
  always_comb begin
    w_win_any = 1'b1;
    w_win_id  = 2'd0;
    casez (w_elig)
      4'b1???: w_win_id = 2'd3;
      4'b01??: w_win_id = 2'd2;
      4'b001?: w_win_id = 2'd1;
      4'b0001: w_win_id = 2'd0;
      default: begin
        w_win_any = 1'b0;
        w_win_id  = 2'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending vector and overflow counter next state
  // --------------------------------------------------------------------------
  always_comb begin
    // Edge has priority over a same-cycle clear of the same bit.
    pend_d = w_edge | (pend_q & ~w_clear);
  end

  always_comb begin
    ovf_d = ovf_q;
    // Any number of lines losing an event in one cycle adds only one.
    if ((w_lost != 4'b0000) && (ovf_q != C_OVF_MAX)) begin
      ovf_d = ovf_q + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Presenter FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (w_win_any) begin
          state_d = ST_PRESENT;
          id_d    = w_win_id;
        end
      end
      ST_PRESENT: begin
        // id is frozen here; later changes to pend or mask cannot withdraw
        // or swap the presented line.
        if (irq_ack) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // valid is registered alongside state so it tracks PRESENT exactly.
  assign valid_d = (state_d == ST_PRESENT);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      ovf_q   <= 4'h0;
      state_q <= ST_IDLE;
      id_q    <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      req_q   <= req;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pend      = pend_q;
  assign ovf_cnt   = ovf_q;

endmodule
`default_nettype wire
